// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/decode/issue sequencer owning pc (ports: imem req/addr/ack/rdata, ir+dec_req to decoder, issue_valid/issue_pc/exec_ready/redirect to execute, halt in, fault/fault_cause/instret out)
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        dec_req,
  output logic        issue_valid,
  output logic [31:0] issue_pc,
  input  logic        exec_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] instret
);
  typedef enum logic [2:0] {FETCH, DECODE, ISSUE, HALTED, FAULT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, ir_n, instret_n, target;
  logic [1:0] cause_n;
  logic live;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= 32'h0000_0013;
      instret <= '0;
      fault_cause <= '0;
      live <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      ir <= ir_n;
      instret <= instret_n;
      fault_cause <= cause_n;
      live <= 1'b1;
    end
  end
  always_comb begin
    target = redirect ? redirect_pc : pc + 32'd4;
    state_n = state;
    pc_n = pc;
    ir_n = ir;
    instret_n = instret;
    cause_n = fault_cause;
    case (state)
      FETCH: begin
        ir_n = imem_ack ? imem_rdata : ir;
        state_n = imem_ack ? DECODE : FETCH;
      end
      DECODE: begin
        state_n = ir[1:0] == 2'b11 ? ISSUE : FAULT;
        cause_n = ir[1:0] == 2'b11 ? 2'd0 : 2'd2;
      end
      ISSUE: if (exec_ready) begin
        instret_n = instret + 32'd1;
        pc_n = target;
        state_n = target[1:0] != 2'b00 ? FAULT : halt ? HALTED : FETCH;
        cause_n = target[1:0] != 2'b00 ? 2'd1 : fault_cause;
      end
      HALTED: state_n = halt ? HALTED : FETCH;
      default: ;
    endcase
  end
  always_comb begin
    imem_req = live && state == FETCH;
    imem_addr = pc;
    dec_req = state == DECODE;
    issue_valid = state == ISSUE;
    issue_pc = pc;
    fault = state == FAULT;
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
  logic clk, reset, imem_req, imem_ack, dec_req, issue_valid, exec_ready, redirect, halt, fault;
  logic [31:0] imem_addr, imem_rdata, ir, issue_pc, redirect_pc, instret;
  logic [1:0] fault_cause;
  typedef struct {logic [31:0] pc; logic [31:0] ir; logic [31:0] cnt;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] mem [logic [31:0]];
  int n_checks = 0, n_fail = 0, wait_cycles = 0, wcnt = 0;
  int dec_cnt = 0, iv_cnt = 0, req_cnt = 0, base;
  fetch_sequencer dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir), .dec_req(dec_req),
    .issue_valid(issue_valid), .issue_pc(issue_pc), .exec_ready(exec_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .fault(fault),
    .fault_cause(fault_cause), .instret(instret)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] p, input logic [31:0] w, input logic [31:0] c);
    exp_t x;
    x.pc = p; x.ir = w; x.cnt = c;
    q.push_back(x);
  endtask
  task automatic check_reset();
    check("rst_imem_req", {31'd0, imem_req}, 0);
    check("rst_dec_req", {31'd0, dec_req}, 0);
    check("rst_issue_valid", {31'd0, issue_valid}, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_issue_pc", issue_pc, 0);
    check("rst_ir", ir, 32'h0000_0013);
    check("rst_fault", {31'd0, fault}, 0);
    check("rst_fault_cause", {30'd0, fault_cause}, 0);
    check("rst_instret", instret, 0);
  endtask
  task automatic reset_dut();
    check("queue_drained", q.size(), 0);
    @(posedge clk); #1;
    reset = 1; exec_ready = 0; redirect = 0; halt = 0; wait_cycles = 0;
    #1 check_reset();
    @(posedge clk); #1;
    q.delete();
    reset = 0;
  endtask
  // memory model: ack after wait_cycles of a held request, drops everything on reset
  initial forever begin
    @(posedge clk); #1;
    if (reset || !imem_req) begin
      imem_ack = 0; wcnt = 0;
    end else if (wcnt == wait_cycles) begin
      imem_ack = 1;
      imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 32'h0000_0093;
      wcnt = 0;
    end else begin
      imem_ack = 0; wcnt++;
    end
  end
  always @(negedge clk) begin
    if (!reset) begin
      if (dec_req) dec_cnt++;
      if (issue_valid) iv_cnt++;
      if (imem_req) req_cnt++;
      if (issue_valid && exec_ready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_issue: got pc %h expected no issue", issue_pc);
        end else begin
          e = q.pop_front();
          check("sb_issue_pc", issue_pc, e.pc);
          check("sb_ir", ir, e.ir);
          check("sb_instret", instret, e.cnt);
        end
      end
    end
  end
  initial begin
    reset = 1; imem_ack = 0; imem_rdata = 0; exec_ready = 0;
    redirect = 0; redirect_pc = 0; halt = 0;
    // sequential zero-wait stream
    reset_dut();
    exec_ready = 1;
    base = dec_cnt;
    push(0, 32'h93, 0); push(4, 32'h93, 1); push(8, 32'h93, 2);
    tick(1);
    check("t1_req0", {31'd0, imem_req}, 1);
    check("t1_addr0", imem_addr, 0);
    tick(3);
    check("t1_addr4", imem_addr, 4);
    tick(3);
    check("t1_addr8", imem_addr, 8);
    tick(3);
    check("t1_instret", instret, 3);
    check("t1_dec_pulses", dec_cnt - base, 3);
    exec_ready = 0;
    tick(2);
    // delayed ack at 0x10, then a stalled issue redirected to 0x100
    reset_dut();
    redirect = 1; redirect_pc = 32'h10; exec_ready = 1;
    mem[32'h10] = 32'h0000_0113;
    push(0, 32'h93, 0);
    tick(2);
    wait_cycles = 4;
    tick(2);
    exec_ready = 0;
    for (int i = 0; i < 5; i++) begin
      check("t2_req_held", {31'd0, imem_req}, 1);
      check("t2_addr_held", imem_addr, 32'h10);
      check("t2_ir_held", ir, 32'h93);
      tick(1);
    end
    check("t2_req_drop", {31'd0, imem_req}, 0);
    check("t2_dec_req", {31'd0, dec_req}, 1);
    check("t2_ir_load", ir, 32'h113);
    tick(1);
    push(32'h10, 32'h113, 1);
    for (int i = 0; i < 7; i++) begin
      check("t3_issue_valid", {31'd0, issue_valid}, 1);
      check("t3_issue_pc", issue_pc, 32'h10);
      if (i == 6) begin
        exec_ready = 1; redirect_pc = 32'h100; wait_cycles = 0;
      end
      tick(1);
    end
    check("t3_valid_drop", {31'd0, issue_valid}, 0);
    check("t3_redirect_addr", imem_addr, 32'h100);
    check("t3_instret", instret, 2);
    exec_ready = 0; redirect = 0;
    tick(4);
    check("t3_instret_once", instret, 2);
    check("t3_stalled_pc", issue_pc, 32'h100);
    // misaligned redirect
    reset_dut();
    redirect = 1; redirect_pc = 32'h102; exec_ready = 1;
    push(0, 32'h93, 0);
    tick(4);
    check("t4_fault", {31'd0, fault}, 1);
    check("t4_cause", {30'd0, fault_cause}, 1);
    check("t4_pc", imem_addr, 32'h102);
    check("t4_instret", instret, 1);
    base = req_cnt;
    tick(5);
    check("t4_no_req", req_cnt - base, 0);
    check("t4_sticky", {31'd0, fault}, 1);
    // compressed encoding
    reset_dut();
    mem[0] = 32'h0000_4501; exec_ready = 1;
    base = iv_cnt;
    tick(2);
    check("t5_dec_req", {31'd0, dec_req}, 1);
    check("t5_ir", ir, 32'h4501);
    tick(1);
    check("t5_fault", {31'd0, fault}, 1);
    check("t5_cause", {30'd0, fault_cause}, 2);
    tick(4);
    check("t5_no_issue", iv_cnt - base, 0);
    check("t5_instret", instret, 0);
    mem.delete(0);
    // halt at 0x20
    reset_dut();
    redirect = 1; redirect_pc = 32'h20; exec_ready = 1;
    push(0, 32'h93, 0); push(32'h20, 32'h93, 1);
    tick(4);
    check("t6_addr20", imem_addr, 32'h20);
    redirect = 0; halt = 1;
    tick(3);
    check("t6_halt_valid", {31'd0, issue_valid}, 0);
    check("t6_instret", instret, 2);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t6_halt_req", {31'd0, imem_req}, 0);
    end
    halt = 0;
    tick(1);
    check("t6_resume_req", {31'd0, imem_req}, 1);
    check("t6_resume_addr", imem_addr, 32'h24);
    exec_ready = 0;
    tick(3);
    // reset during a memory wait
    reset_dut();
    exec_ready = 1;
    push(0, 32'h93, 0);
    tick(2);
    wait_cycles = 3;
    tick(4);
    check("t7_waiting_req", {31'd0, imem_req}, 1);
    check("t7_waiting_addr", imem_addr, 4);
    check("t7_instret", instret, 1);
    reset = 1;
    #1 check_reset();
    tick(2);
    // instret wrap
    reset_dut();
    tick(3);
    check("t8_in_issue", {31'd0, issue_valid}, 1);
    force dut.instret = 32'hFFFF_FFFF;
    #1 release dut.instret;
    check("t8_preload", instret, 32'hFFFF_FFFF);
    push(0, 32'h93, 32'hFFFF_FFFF);
    exec_ready = 1;
    tick(1);
    check("t8_wrap", instret, 0);
    exec_ready = 0;
    tick(2);
    check("final_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
